// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a 2-flop synchronizer followed by a
// counter-qualified debounce FSM. Produces a clean level plus one-cycle
// press/release pulses. All state uses a synchronous active-low reset.
module btn_debounce #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               s_reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Count value on the edge that commits the new level.
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntFirst = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    StStableLo,
    StChkHi,
    StStableHi,
    StChkLo
  } state_e;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             commit_hi, commit_lo;
    logic             s;

    assign s = sync2_q[i];

    // State, counter and registered outputs; reset wins over every update.
    always_ff @(posedge clk) begin
      if (!s_reset_n) begin
        state_q   <= StStableLo;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next state and count; any sample equal to the stable level clears the count.
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      commit_hi = 1'b0;
      commit_lo = 1'b0;
      unique case (state_q)
        StStableLo: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d   = StStableHi;
              commit_hi = 1'b1;
            end else begin
              state_d = StChkHi;
              cnt_d   = CntFirst;
            end
          end
        end
        StChkHi: begin
          if (!s) begin
            state_d = StStableLo;
          end else if (cnt_q == CntLast) begin
            state_d   = StStableHi;
            commit_hi = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStableHi: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d   = StStableLo;
              commit_lo = 1'b1;
            end else begin
              state_d = StChkLo;
              cnt_d   = CntFirst;
            end
          end
        end
        StChkLo: begin
          if (s) begin
            state_d = StStableHi;
          end else if (cnt_q == CntLast) begin
            state_d   = StStableLo;
            commit_lo = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StStableLo;
        end
      endcase
    end

    // Output next values: pulses only on a commit edge, level follows the commit.
    always_comb begin
      level_d   = level_q;
      press_d   = commit_hi;
      release_d = commit_lo;
      if (commit_hi) begin
        level_d = 1'b1;
      end else if (commit_lo) begin
        level_d = 1'b0;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE_CYCLES=4, NUM_BTN=4. A history-window
// model (last N synchronized samples all opposite the level => commit) is
// compared every cycle, plus hand-computed checks at the key edges.
module tb_btn_debounce;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clk;
  logic          s_reset_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  btn_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .s_reset_n  (s_reset_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: two-stage pin delay, then a window of the most recent samples the
  // conditioner has seen since reset. A commit happens when the last DB
  // samples all differ from the current level.
  logic [NB-1:0] m_p1, m_p2, m_level, m_press, m_release;
  logic [DB-1:0] m_hist [NB];
  int            m_n    [NB];
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_valid <= 1'b1;
    for (int i = 0; i < NB; i++) begin
      automatic logic [DB-1:0] h;
      automatic int            n;
      automatic logic          commit;
      if (!s_reset_n) begin
        m_p1[i]      <= 1'b0;
        m_p2[i]      <= 1'b0;
        m_level[i]   <= 1'b0;
        m_press[i]   <= 1'b0;
        m_release[i] <= 1'b0;
        m_hist[i]    <= '0;
        m_n[i]       <= 0;
      end else begin
        h      = {m_hist[i][DB-2:0], m_p2[i]};
        n      = (m_n[i] < DB) ? m_n[i] + 1 : DB;
        commit = (n == DB) && (h == (m_level[i] ? {DB{1'b0}} : {DB{1'b1}}));
        m_p1[i]      <= btn_in[i];
        m_p2[i]      <= m_p1[i];
        m_hist[i]    <= h;
        m_n[i]       <= n;
        m_level[i]   <= commit ? ~m_level[i] : m_level[i];
        m_press[i]   <= commit && !m_level[i];
        m_release[i] <= commit && m_level[i];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks = checks + 1;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        errors = errors + 1;
        $display("FAIL model cycle %0d: level %b want %b, press %b want %b, release %b want %b",
                 cyc, btn_level, m_level, btn_press, m_press, btn_release, m_release);
      end
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    s_reset_n = 1'b0;
    btn_in    = '0;
    @(negedge clk);

    // 1. Reset, then idle with no pulses.
    step(5);
    chk("reset level", btn_level, 4'b0000);
    chk("reset press", btn_press, 4'b0000);
    chk("reset release", btn_release, 4'b0000);
    s_reset_n = 1'b1;
    step(20);
    chk("idle level", btn_level, 4'b0000);

    // 2. Clean press on ch0: commit at edge 6.
    btn_in[0] = 1'b1;
    step(5);
    chk("t2 edge5 press", btn_press, 4'b0000);
    chk("t2 edge5 level", btn_level, 4'b0000);
    step(1);
    chk("t2 edge6 press", btn_press, 4'b0001);
    chk("t2 edge6 level", btn_level, 4'b0001);
    step(1);
    chk("t2 edge7 press", btn_press, 4'b0000);

    // 3. Bouncing ch1: 1,1,1,0 three times, then held high.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        btn_in[1] = (k < 3);
        step(1);
        chk("t3 bounce level", btn_level, 4'b0001);
      end
    end
    btn_in[1] = 1'b1;
    step(5);
    chk("t3 edge5 press", btn_press, 4'b0000);
    step(1);
    chk("t3 edge6 press", btn_press, 4'b0010);
    chk("t3 edge6 level", btn_level, 4'b0011);
    step(1);
    chk("t3 edge7 press", btn_press, 4'b0000);

    // 4. Release on ch0.
    btn_in[0] = 1'b0;
    step(5);
    chk("t4 edge5 release", btn_release, 4'b0000);
    step(1);
    chk("t4 edge6 release", btn_release, 4'b0001);
    chk("t4 edge6 level", btn_level, 4'b0010);
    chk("t4 edge6 press", btn_press, 4'b0000);
    step(1);
    chk("t4 edge7 release", btn_release, 4'b0000);

    // 5. Bring ch3 high, then ch2 rises while ch3 falls in the same cycle.
    btn_in[3] = 1'b1;
    step(8);
    chk("t5 ch3 high", btn_level, 4'b1010);
    btn_in[2] = 1'b1;
    btn_in[3] = 1'b0;
    step(5);
    chk("t5 edge5 press", btn_press, 4'b0000);
    step(1);
    chk("t5 edge6 press", btn_press, 4'b0100);
    chk("t5 edge6 release", btn_release, 4'b1000);
    chk("t5 edge6 level", btn_level, 4'b0110);
    step(1);

    // 6. Reset in the middle of ch0 qualification, pins kept as they are.
    btn_in[0] = 1'b1;
    step(3);
    s_reset_n = 1'b0;
    step(1);
    chk("t6 reset level", btn_level, 4'b0000);
    chk("t6 reset press", btn_press, 4'b0000);
    s_reset_n = 1'b1;
    step(5);
    chk("t6 edge5 press", btn_press, 4'b0000);
    step(1);
    chk("t6 edge6 press", btn_press, 4'b0111);
    chk("t6 edge6 level", btn_level, 4'b0111);
    step(1);
    chk("t6 edge7 press", btn_press, 4'b0000);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
